// File: rtl/crc32_stream.sv
// Streaming CRC-32 engine: framed valid/ready beats in, one CRC result per frame out.
// Byte-serial combinational fold parameterised by POLY and REFLECT, with a residue-match flag.
module crc32_stream #(
  parameter int unsigned DATA_W  = 32,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
  parameter bit          REFLECT = 1'b1,
  parameter logic [31:0] RESIDUE = 32'h2144DF1C
) (
  input  logic                Clk,
  input  logic                ARst,
  input  logic                InValid,
  output logic                InReady,
  input  logic [DATA_W-1:0]   InData,
  input  logic [DATA_W/8-1:0] InKeep,
  input  logic                InFirst,
  input  logic                InLast,
  output logic [31:0]         CrcOut,
  output logic                CrcOutValid,
  input  logic                CrcOutReady,
  output logic                CrcMatch
);

  localparam int unsigned NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_out_q, crc_out_d;
  logic        out_valid_q, out_valid_d;
  logic        match_q, match_d;
  logic        in_ready_q, in_ready_d;

  logic              accept;
  logic [31:0]       fold;
  logic [31:0]       fin;
  logic [DATA_W-1:0] data_sh;
  logic [NB-1:0]     keep_sh;
  logic [7:0]        byte_v;
  logic              fb;

  assign accept = InValid && in_ready_q;

  // Shifts instead of variable bit-selects keep the unroll free of index arithmetic.
  always_comb begin
    fold    = (state_q == IDLE || InFirst) ? INIT : crc_q;
    data_sh = InData;
    keep_sh = InKeep;
    byte_v  = '0;
    fb      = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      byte_v = data_sh[7:0];
      if (!InLast || keep_sh[0]) begin
        for (int unsigned j = 0; j < 8; j++) begin
          fb     = fold[31] ^ (REFLECT ? byte_v[0] : byte_v[7]);
          fold   = {fold[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
          byte_v = REFLECT ? (byte_v >> 1) : (byte_v << 1);
        end
      end
      data_sh = data_sh >> 8;
      keep_sh = keep_sh >> 1;
    end
    fin = (REFLECT ? {<<{fold}} : fold) ^ XOR_OUT;
  end

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    crc_out_d   = crc_out_q;
    out_valid_d = out_valid_q;
    match_d     = match_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          crc_d = fold;
          if (InLast) begin
            crc_out_d   = fin;
            match_d     = (fin == RESIDUE);
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (CrcOutReady) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d != HOLD);
  end

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      state_q     <= IDLE;
      crc_q       <= '0;
      crc_out_q   <= '0;
      out_valid_q <= 1'b0;
      match_q     <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      crc_out_q   <= crc_out_d;
      out_valid_q <= out_valid_d;
      match_q     <= match_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign InReady     = in_ready_q;
  assign CrcOut      = crc_out_q;
  assign CrcOutValid = out_valid_q;
  assign CrcMatch    = match_q;

endmodule

// File: tb/tb_crc32_stream.sv
// Self-checking bench for crc32_stream: directed vector table, reset/backpressure sequences,
// randomized frames against a shift-right reflected CRC-32 reference, and an 8-bit-wide instance.
module tb_crc32_stream;

  logic        Clk = 1'b0;
  logic        ARst = 1'b1;
  logic        InValid = 1'b0, InFirst = 1'b0, InLast = 1'b0, CrcOutReady = 1'b0;
  logic [31:0] InData = '0;
  logic [3:0]  InKeep = '0;
  logic        InReady, CrcOutValid, CrcMatch;
  logic [31:0] CrcOut;

  logic        v8 = 1'b0, f8 = 1'b0, l8 = 1'b0, k8 = 1'b0, r8 = 1'b0;
  logic [7:0]  d8 = '0;
  logic        rdy8, ov8, m8;
  logic [31:0] out8;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  crc32_stream #(.DATA_W(32)) u32 (
    .Clk(Clk), .ARst(ARst), .InValid(InValid), .InReady(InReady), .InData(InData),
    .InKeep(InKeep), .InFirst(InFirst), .InLast(InLast), .CrcOut(CrcOut),
    .CrcOutValid(CrcOutValid), .CrcOutReady(CrcOutReady), .CrcMatch(CrcMatch)
  );

  crc32_stream #(.DATA_W(8)) u8 (
    .Clk(Clk), .ARst(ARst), .InValid(v8), .InReady(rdy8), .InData(d8),
    .InKeep(k8), .InFirst(f8), .InLast(l8), .CrcOut(out8),
    .CrcOutValid(ov8), .CrcOutReady(r8), .CrcMatch(m8)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    bit          first;
    bit          last;
    logic [31:0] exp;
    bit          exp_match;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Standard right-shifting reflected CRC-32 (Ethernet), byte list in transmission order.
  function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[k]) begin
      c ^= {24'h0, q[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c ^ 32'hFFFFFFFF;
  endfunction

  task automatic send(input logic [31:0] d, input logic [3:0] k, input bit first, input bit last);
    int n = 0;
    InData = d; InKeep = k; InFirst = first; InLast = last; InValid = 1'b1;
    while (!InReady && n < 50) begin
      @(posedge Clk); #1; n++;
    end
    if (!InReady) check("in_ready_wait", {31'h0, InReady}, 32'h1);
    @(posedge Clk); #1;
    InValid = 1'b0; InFirst = 1'b0; InLast = 1'b0;
  endtask

  task automatic collect(input string name, input logic [31:0] exp, input bit exp_match);
    check({name, "_valid"}, {31'h0, CrcOutValid}, 32'h1);
    check({name, "_crc"}, CrcOut, exp);
    check({name, "_match"}, {31'h0, CrcMatch}, {31'h0, exp_match});
    CrcOutReady = 1'b1;
    @(posedge Clk); #1;
    CrcOutReady = 1'b0;
    check({name, "_valid_clr"}, {31'h0, CrcOutValid}, 32'h0);
    check({name, "_inready"}, {31'h0, InReady}, 32'h1);
  endtask

  task automatic run_rows(input int lo, input int hi, input string name);
    for (int i = lo; i <= hi; i++) begin
      send(tbl[i].data, tbl[i].keep, tbl[i].first, tbl[i].last);
      if (tbl[i].last) collect(name, tbl[i].exp, tbl[i].exp_match);
    end
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [31:0] d, exp, held;
    logic [3:0]  k;
    int          nb, kb, dl;
    bit          first;

    // 0-2 check value, 3-6 residue, 7 empty, 8 stray beat then 9-11 restart
    tbl.push_back('{32'h34333231, 4'hF, 1, 0, 32'h0, 0});
    tbl.push_back('{32'h38373635, 4'hF, 0, 0, 32'h0, 0});
    tbl.push_back('{32'h00000039, 4'h1, 0, 1, 32'hCBF43926, 0});
    tbl.push_back('{32'h34333231, 4'hF, 1, 0, 32'h0, 0});
    tbl.push_back('{32'h38373635, 4'hF, 0, 0, 32'h0, 0});
    tbl.push_back('{32'hF4392639, 4'hF, 0, 0, 32'h0, 0});
    tbl.push_back('{32'h000000CB, 4'h1, 0, 1, 32'h2144DF1C, 1});
    tbl.push_back('{32'hDEADBEEF, 4'h0, 1, 1, 32'h00000000, 0});
    tbl.push_back('{32'h34333231, 4'hF, 1, 0, 32'h0, 0});
    tbl.push_back('{32'h34333231, 4'hF, 1, 0, 32'h0, 0});
    tbl.push_back('{32'h38373635, 4'hF, 0, 0, 32'h0, 0});
    tbl.push_back('{32'h00000039, 4'h1, 0, 1, 32'hCBF43926, 0});

    repeat (2) @(posedge Clk);
    #1;
    check("rst_crc", CrcOut, 32'h0);
    check("rst_valid", {31'h0, CrcOutValid}, 32'h0);
    check("rst_match", {31'h0, CrcMatch}, 32'h0);
    check("rst_inready", {31'h0, InReady}, 32'h0);
    ARst = 1'b0;
    #1 check("inready_before_edge", {31'h0, InReady}, 32'h0);
    @(posedge Clk); #1;
    check("inready_after_edge", {31'h0, InReady}, 32'h1);

    run_rows(0, 2, "check_value");
    run_rows(3, 6, "residue");
    run_rows(7, 7, "empty");
    run_rows(8, 11, "restart");

    // Backpressure with junk beats offered while the result is held
    run_rows(0, 1, "bp");
    send(tbl[2].data, tbl[2].keep, 0, 1);
    held = CrcOut;
    check("bp_crc", held, 32'hCBF43926);
    InData = 32'h12345678; InKeep = 4'hF; InFirst = 1'b1; InLast = 1'b1; InValid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("bp_inready", {31'h0, InReady}, 32'h0);
      check("bp_stable", CrcOut, held);
      check("bp_valid", {31'h0, CrcOutValid}, 32'h1);
      @(posedge Clk); #1;
    end
    InValid = 1'b0; InFirst = 1'b0; InLast = 1'b0;
    collect("bp_release", 32'hCBF43926, 0);
    run_rows(0, 2, "after_bp");

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      q.delete();
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        d = $urandom;
        if (b == nb - 1) begin
          kb = $urandom_range(0, 4);
          k = 4'((5'd1 << kb) - 5'd1);
        end else begin
          kb = 4;
          k = 4'($urandom);
        end
        for (int j = 0; j < kb; j++) q.push_back(8'(d >> (8 * j)));
        first = (b == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge Clk); #1;
        end
        send(d, k, first, b == nb - 1);
      end
      exp = ref_crc(q);
      dl = $urandom_range(0, 3);
      for (int c = 0; c < dl; c++) begin
        check("rand_hold", {31'h0, CrcOutValid}, 32'h1);
        @(posedge Clk); #1;
      end
      collect("random", exp, exp == 32'h2144DF1C);
    end

    // Reset mid-frame, immediately visible
    run_rows(0, 1, "rst_mid");
    #2 ARst = 1'b1;
    #1;
    check("rst_mid_inready", {31'h0, InReady}, 32'h0);
    check("rst_mid_crc", CrcOut, 32'h0);
    ARst = 1'b0;
    @(posedge Clk); #1;

    // Reset while holding a matching result
    run_rows(3, 5, "rst_hold");
    send(tbl[6].data, tbl[6].keep, 0, 1);
    check("rst_hold_pre_match", {31'h0, CrcMatch}, 32'h1);
    #2 ARst = 1'b1;
    #1;
    check("rst_hold_crc", CrcOut, 32'h0);
    check("rst_hold_valid", {31'h0, CrcOutValid}, 32'h0);
    check("rst_hold_match", {31'h0, CrcMatch}, 32'h0);
    @(posedge Clk); #1;
    ARst = 1'b0;
    #1 check("rel_inready_low", {31'h0, InReady}, 32'h0);
    @(posedge Clk); #1;
    check("rel_inready_high", {31'h0, InReady}, 32'h1);
    run_rows(0, 2, "after_rst");

    // DATA_W = 8 instance
    for (int i = 0; i < 9; i++) begin
      int n = 0;
      d8 = 8'h31 + 8'(i); k8 = 1'b1; f8 = (i == 0); l8 = (i == 8); v8 = 1'b1;
      while (!rdy8 && n < 50) begin
        @(posedge Clk); #1; n++;
      end
      if (!rdy8) check("w8_ready_wait", {31'h0, rdy8}, 32'h1);
      @(posedge Clk); #1;
    end
    v8 = 1'b0; f8 = 1'b0; l8 = 1'b0;
    check("w8_valid", {31'h0, ov8}, 32'h1);
    check("w8_crc", out8, 32'hCBF43926);
    check("w8_match", {31'h0, m8}, 32'h0);
    r8 = 1'b1;
    @(posedge Clk); #1;
    r8 = 1'b0;
    check("w8_valid_clr", {31'h0, ov8}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
